// File: rtl/ariane_pkg.sv
// Shared frontend types and constants for the gshare branch history table.
package ariane_pkg;

  localparam int unsigned VLEN                 = 64;
  localparam bit          RVC                  = 1'b1;
  localparam int unsigned INSTR_PER_FETCH      = RVC ? 2 : 1;
  localparam int unsigned GSHARE_HIST_BITS     = 8;
  // Update-port history field is sized for the longest supported GHR.
  localparam int unsigned GSHARE_MAX_HIST_BITS = 16;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  typedef struct packed {
    logic                            valid;
    logic [VLEN-1:0]                 pc;
    logic                            taken;
    logic                            mispredict;
    logic [GSHARE_MAX_HIST_BITS-1:0] hist;
  } gshare_update_t;

  typedef enum logic {
    GSHARE_IDLE,
    GSHARE_INIT
  } gshare_state_e;

endpackage

// File: rtl/gshare_sat_ctr.sv
// Next-state logic for a CTR_BITS-wide saturating up/down counter.
module gshare_sat_ctr #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                taken_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  localparam logic [CTR_BITS-1:0] CtrMax = '1;

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CtrMax) ctr_o = ctr_i + CTR_BITS'(1);
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/gshare_bht.sv
// Gshare branch history table: flop-based counter rows indexed by PC xor global
// history, a speculative GHR with mispredict restore, and a row-sweep flush.
//   state | meaning
//   IDLE  | predicting and training
//   INIT  | re-initialising one row per cycle, training and history frozen
module gshare_bht import ariane_pkg::*; #(
  parameter int unsigned NR_ENTRIES = 1024,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned HIST_BITS  = GSHARE_HIST_BITS
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic                                  debug_mode_i,
  input  logic [VLEN-1:0]                       vpc_i,
  input  logic                                  spec_valid_i,
  input  logic                                  spec_taken_i,
  input  gshare_update_t                        bht_update_i,
  output bht_prediction_t [INSTR_PER_FETCH-1:0] bht_prediction_o,
  output logic [HIST_BITS-1:0]                  hist_o,
  output logic                                  init_busy_o
);

  localparam int unsigned NR_ROWS       = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS      = $clog2(NR_ROWS);
  localparam int unsigned ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned SLOT_BITS     = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;
  localparam int unsigned OFFSET        = RVC ? 1 : 2;
  localparam int unsigned ROW_LSB       = ROW_ADDR_BITS + OFFSET;

  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(2 ** (CTR_BITS - 1));
  localparam logic [ROW_BITS-1:0] LastRow = ROW_BITS'(NR_ROWS - 1);

  typedef struct packed {
    logic                valid;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;
  typedef entry_t [INSTR_PER_FETCH-1:0] row_t;

  localparam entry_t InitEntry = '{valid: 1'b0, ctr: CtrInit};

  row_t                 tbl_q [NR_ROWS];
  gshare_state_e        state_q, state_d;
  logic [ROW_BITS-1:0]  init_row_q, init_row_d;
  logic [HIST_BITS-1:0] hist_q, hist_d;

  logic [ROW_BITS-1:0]  rd_row, upd_row;
  logic [SLOT_BITS-1:0] upd_slot;
  logic [CTR_BITS-1:0]  upd_ctr_cur, upd_ctr_nxt;
  logic                 upd_en;
  logic                 unused_bits;

  assign init_busy_o = (state_q == GSHARE_INIT);
  assign hist_o      = hist_q;

  assign rd_row  = vpc_i[ROW_LSB +: ROW_BITS] ^ ROW_BITS'(hist_q);
  assign upd_row = bht_update_i.pc[ROW_LSB +: ROW_BITS]
                 ^ ROW_BITS'(bht_update_i.hist[HIST_BITS-1:0]);

  generate
    if (INSTR_PER_FETCH > 1) begin : g_slot
      assign upd_slot = bht_update_i.pc[ROW_LSB-1:OFFSET];
    end else begin : g_no_slot
      assign upd_slot = '0;
    end
  endgenerate

  // Only part of the PC and history fields feed the index.
  assign unused_bits = ^{vpc_i, bht_update_i.pc, bht_update_i.hist};

  assign upd_en      = bht_update_i.valid & ~debug_mode_i & ~init_busy_o;
  assign upd_ctr_cur = tbl_q[upd_row][upd_slot].ctr;

  gshare_sat_ctr #(
    .CTR_BITS(CTR_BITS)
  ) i_sat_ctr (
    .ctr_i  (upd_ctr_cur),
    .taken_i(bht_update_i.taken),
    .ctr_o  (upd_ctr_nxt)
  );

  always_comb begin
    bht_prediction_o = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      bht_prediction_o[s].valid = tbl_q[rd_row][s].valid & ~init_busy_o;
      bht_prediction_o[s].taken = tbl_q[rd_row][s].ctr[CTR_BITS-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    init_row_d = init_row_q;
    unique case (state_q)
      GSHARE_IDLE: begin
        if (flush_i) begin
          state_d    = GSHARE_INIT;
          init_row_d = '0;
        end
      end
      GSHARE_INIT: begin
        if (flush_i) begin
          init_row_d = '0;
        end else if (init_row_q == LastRow) begin
          state_d    = GSHARE_IDLE;
          init_row_d = '0;
        end else begin
          init_row_d = init_row_q + 1'b1;
        end
      end
    endcase
  end

  // Mispredict restore wins over a same-cycle speculative shift.
  always_comb begin
    hist_d = hist_q;
    if (flush_i) begin
      hist_d = '0;
    end else if (!debug_mode_i && !init_busy_o) begin
      if (bht_update_i.valid && bht_update_i.mispredict) begin
        hist_d = HIST_BITS'({bht_update_i.hist, bht_update_i.taken});
      end else if (spec_valid_i) begin
        hist_d = HIST_BITS'({hist_q, spec_taken_i});
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= GSHARE_IDLE;
      init_row_q <= '0;
      hist_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_row_q <= init_row_d;
      hist_q     <= hist_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_q <= '{default: '0};
    end else if (init_busy_o) begin
      tbl_q[init_row_q] <= {INSTR_PER_FETCH{InitEntry}};
    end else if (upd_en) begin
      tbl_q[upd_row][upd_slot] <= '{valid: 1'b1, ctr: upd_ctr_nxt};
    end
  end

endmodule
